// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_lhs,
  input  logic [31:0] req0_rhs,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_res,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_lhs,
  input  logic [31:0] req1_rhs,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_res,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_lhs,
  output logic [31:0] alu_rhs,
  input  logic [31:0] alu_res,
  output logic        busy,
  output logic [31:0] ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   rr_ptr;
  logic   owner;
  logic   gnt0;
  logic   gnt1;
  logic   rsp_fire;

  // rr_ptr names the port that wins a tie; it always points away from the last served port.
  assign gnt1       = req1_valid & (~req0_valid | rr_ptr);
  assign gnt0       = req0_valid & ~gnt1;
  assign req0_ready = (state == IDLE) & gnt0;
  assign req1_ready = (state == IDLE) & gnt1;
  assign rsp_fire   = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

  // The alu_* registers double as the latched operands; they are non-zero only during EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      owner      <= 1'b0;
      alu_op     <= '0;
      alu_lhs    <= '0;
      alu_rhs    <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_res   <= '0;
      rsp1_res   <= '0;
      busy       <= 1'b0;
      ops_done   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 | gnt1) begin
            owner   <= gnt1;
            alu_op  <= gnt1 ? req1_op  : req0_op;
            alu_lhs <= gnt1 ? req1_lhs : req0_lhs;
            alu_rhs <= gnt1 ? req1_rhs : req0_rhs;
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp0_valid <= ~owner;
          rsp1_valid <= owner;
          rsp0_res   <= owner ? '0 : alu_res;
          rsp1_res   <= owner ? alu_res : '0;
          alu_op     <= '0;
          alu_lhs    <= '0;
          alu_rhs    <= '0;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_fire) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_res   <= '0;
            rsp1_res   <= '0;
            rr_ptr     <= ~owner;
            ops_done   <= ops_done + 32'd1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SLT = 4'h5;
  localparam logic [3:0] OP_SRA = 4'h8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [3:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_lhs, req0_rhs, req1_lhs, req1_rhs;
  logic [31:0] rsp0_res, rsp1_res, alu_lhs, alu_rhs, alu_res, ops_done;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Stand-in for the shared ALU; unknown ops return 'hA like the real one.
  always_comb begin
    alu_res = 32'h0000000A;
    case (alu_op)
      OP_ADD: alu_res = alu_lhs + alu_rhs;
      OP_SUB: alu_res = alu_lhs - alu_rhs;
      OP_XOR: alu_res = alu_lhs ^ alu_rhs;
      OP_SLT: alu_res = {31'd0, $signed(alu_lhs) < $signed(alu_rhs)};
      OP_SRA: alu_res = $unsigned($signed(alu_lhs) >>> alu_rhs[4:0]);
      default: alu_res = 32'h0000000A;
    endcase
  end

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_lhs(req0_lhs), .req0_rhs(req0_rhs),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_res(rsp0_res),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_lhs(req1_lhs), .req1_rhs(req1_rhs),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_res(rsp1_res),
    .alu_op(alu_op), .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_res(alu_res),
    .busy(busy), .ops_done(ops_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 0; req0_op = 0; req0_lhs = 0; req0_rhs = 0; rsp0_ready = 1;
    req1_valid = 0; req1_op = 0; req1_lhs = 0; req1_rhs = 0; rsp1_ready = 1;
    do_reset();

    // reset state
    chk("rst_busy", busy, 0);
    chk("rst_ops_done", ops_done, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_lhs", alu_lhs, 0);

    // single ADD on port 0: accept at T, EXEC at T+1, RESP at T+2
    req0_valid = 1; req0_op = OP_ADD; req0_lhs = 5; req0_rhs = 7;
    #1;
    chk("add_req0_ready_T", req0_ready, 1);
    chk("add_req1_ready_T", req1_ready, 0);
    tick();
    req0_valid = 0;
    chk("add_alu_op", alu_op, OP_ADD);
    chk("add_alu_lhs", alu_lhs, 5);
    chk("add_alu_rhs", alu_rhs, 7);
    chk("add_busy_exec", busy, 1);
    chk("add_rsp0_valid_exec", rsp0_valid, 0);
    tick();
    chk("add_rsp0_valid", rsp0_valid, 1);
    chk("add_rsp0_res", rsp0_res, 12);
    chk("add_rsp1_valid", rsp1_valid, 0);
    chk("add_alu_op_resp", alu_op, 0);
    tick();
    chk("add_ops_done", ops_done, 1);
    chk("add_rsp0_valid_after", rsp0_valid, 0);
    chk("add_rsp0_res_after", rsp0_res, 0);
    chk("add_busy_after", busy, 0);

    // both valid from reset: port 0 first, then alternate
    do_reset();
    req0_valid = 1; req0_op = OP_SUB; req0_lhs = 10; req0_rhs = 3;
    req1_valid = 1; req1_op = OP_XOR; req1_lhs = 32'hF0; req1_rhs = 32'h0F;
    #1;
    chk("rr_first_req0_ready", req0_ready, 1);
    chk("rr_first_req1_ready", req1_ready, 0);
    tick(); tick();
    chk("rr_sub_rsp0_res", rsp0_res, 7);
    chk("rr_sub_rsp1_valid", rsp1_valid, 0);
    tick();
    chk("rr_second_req1_ready", req1_ready, 1);
    chk("rr_second_req0_ready", req0_ready, 0);
    tick(); tick();
    chk("rr_xor_rsp1_valid", rsp1_valid, 1);
    chk("rr_xor_rsp1_res", rsp1_res, 32'hFF);
    chk("rr_xor_rsp0_valid", rsp0_valid, 0);
    tick();
    chk("rr_third_req0_ready", req0_ready, 1);
    chk("rr_third_req1_ready", req1_ready, 0);
    tick(); tick();
    chk("rr_third_rsp0_res", rsp0_res, 7);
    tick();
    chk("rr_fourth_req1_ready", req1_ready, 1);
    chk("rr_ops_done", ops_done, 3);
    req0_valid = 0; req1_valid = 0;
    tick(); tick(); tick();

    // response backpressure on port 1
    do_reset();
    req1_valid = 1; req1_op = OP_SLT; req1_lhs = 32'hFFFFFFFF; req1_rhs = 1;
    rsp1_ready = 0;
    #1;
    chk("bp_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 0;
    req0_valid = 1; req0_op = OP_ADD; req0_lhs = 1; req0_rhs = 2;
    chk("bp_req0_ready_exec", req0_ready, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp1_valid", rsp1_valid, 1);
      chk("bp_rsp1_res", rsp1_res, 1);
      chk("bp_req0_ready", req0_ready, 0);
      tick();
    end
    rsp1_ready = 1;
    #1;
    chk("bp_req0_ready_hs", req0_ready, 0);
    tick();
    chk("bp_rsp1_valid_after", rsp1_valid, 0);
    chk("bp_req0_ready_resume", req0_ready, 1);
    chk("bp_ops_done", ops_done, 1);
    tick();
    req0_valid = 0;
    tick(); tick();
    chk("bp_add_done", ops_done, 2);

    // reset during EXEC drops the transaction
    do_reset();
    req0_valid = 1; req0_op = OP_SRA; req0_lhs = 32'h80000000; req0_rhs = 4;
    tick();
    req0_valid = 0;
    chk("rx_alu_op_exec", alu_op, OP_SRA);
    reset = 1;
    tick();
    reset = 0;
    chk("rx_busy", busy, 0);
    chk("rx_rsp0_valid", rsp0_valid, 0);
    chk("rx_ops_done", ops_done, 0);
    chk("rx_alu_op", alu_op, 0);
    tick();
    chk("rx_rsp0_valid_late", rsp0_valid, 0);
    req0_valid = 1;
    req1_valid = 1; req1_op = OP_ADD; req1_lhs = 0; req1_rhs = 0;
    #1;
    chk("rx_rr_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 0; req1_valid = 0;
    tick();
    chk("rx_sra_res", rsp0_res, 32'hF8000000);
    tick();
    tick(); tick(); tick();

    // unimplemented op passes through; ops_done wraps
    do_reset();
    force dut.ops_done = 32'hFFFFFFFF;
    #1;
    release dut.ops_done;
    #1;
    chk("wrap_preset", ops_done, 32'hFFFFFFFF);
    req1_valid = 1; req1_op = 4'hF; req1_lhs = 32'h12345678; req1_rhs = 32'h9;
    tick();
    req1_valid = 0;
    tick();
    chk("unimpl_rsp1_valid", rsp1_valid, 1);
    chk("unimpl_rsp1_res", rsp1_res, 32'h0000000A);
    chk("unimpl_rsp0_res", rsp0_res, 0);
    tick();
    chk("wrap_ops_done", ops_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
